tiny_dnn_ctrl: RTL

TINY_DNN_CTRL -- requirements
Module: tiny_dnn_ctrl

---
 rtl/tiny_dnn_pkg.sv | 21 ++
 rtl/tiny_dnn_dly.sv | 26 ++
 rtl/tiny_dnn_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/tiny_dnn_pkg.sv
// Shared constants, FSM state encoding and the delay-line tag for the tiny DNN issue controller.
package tiny_dnn_pkg;
  localparam int F_SIZE = 1024;
  localparam int ADDR_W = $clog2(F_SIZE);
  localparam int CNT_W  = 16;
  localparam int DLY_N  = 2;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    EXEC,
    BIAS,
    DRAIN
  } state_e;

  // cmp marks the final strobe of a sample; par is the issue parity in that cycle
  typedef struct packed {
    logic cmp;
    logic par;
  } tag_t;
endpackage

// File: rtl/tiny_dnn_dly.sv
// N-stage registered delay line carrying issue parity and completion tag; latency N cycles,
// no backpressure (shifts every cycle), every stage exposed on taps_o.
module tiny_dnn_dly #(
  parameter int N = 2,
  parameter int W = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [W-1:0]        dat_i,
  output logic [W-1:0]        dat_o,
  output logic [N-1:0][W-1:0] taps_o
);
  logic [N-1:0][W-1:0] stg_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stg_q <= '0;
    end else begin
      stg_q[0] <= dat_i;
      for (int i = 1; i < N; i++) stg_q[i] <= stg_q[i-1];
    end
  end

  assign dat_o  = stg_q[N-1];
  assign taps_o = stg_q;
endmodule

// File: rtl/tiny_dnn_ctrl.sv
// Issue/readout controller for a double-banked DNN accumulator core; strobes are combinational from state,
// results retire 3 cycles after the last strobe, issue stalls while the target bank is unread. Option: TINY_DNN_CTRL_BIAS_EN.
module tiny_dnn_ctrl
  import tiny_dnn_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] in_size,
  input  logic [CNT_W-1:0]  n_samples,
  output logic              busy,
  output logic              done,
  output logic              init,
  output logic              exec,
  output logic              bias,
  output logic [ADDR_W-1:0] ra,
  output logic              sum_ip,
  output logic              sum_op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_idx
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] size_q, size_d, ra_q, ra_d;
  logic [CNT_W-1:0]  rem_q, rem_d, out_idx_q, out_idx_d;
  logic              par_q, par_d, rd_ptr_q, rd_ptr_d, done_q, done_d;
  logic [1:0]        bank_vld_q, bank_vld_d;
  logic              init_s, exec_s, bias_s, smp_end, run_ld, accept;
  logic              stall, inflight_same, inflight_any;
  tag_t              dly_in, dly_out;
  tag_t [DLY_N-1:0]  dly_taps;

  tiny_dnn_dly #(.N(DLY_N), .W($bits(tag_t))) u_dly (
    .clk   (clk),
    .reset (reset),
    .dat_i (dly_in),
    .dat_o (dly_out),
    .taps_o(dly_taps)
  );

  // A same-parity tag still in flight means that bank is about to fill; treat it as occupied.
  always_comb begin
    inflight_same = 1'b0;
    inflight_any  = 1'b0;
    for (int i = 0; i < DLY_N; i++) begin
      if (dly_taps[i].cmp) begin
        inflight_any = 1'b1;
        if (dly_taps[i].par == par_q) inflight_same = 1'b1;
      end
    end
  end

  assign stall = bank_vld_q[par_q] || inflight_same;

  always_comb begin
    state_d = state_q;
    size_d  = size_q;
    ra_d    = ra_q;
    rem_d   = rem_q;
    par_d   = par_q;
    done_d  = 1'b0;
    run_ld  = 1'b0;
    init_s  = 1'b0;
    exec_s  = 1'b0;
    bias_s  = 1'b0;
    smp_end = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (n_samples == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = INIT;
            size_d  = in_size;
            rem_d   = n_samples;
            par_d   = 1'b0;
            run_ld  = 1'b1;
          end
        end
      end
      INIT: begin
        if (!stall) begin
          init_s = 1'b1;
          ra_d   = '0;
          if (size_q != '0) state_d = EXEC;
`ifdef TINY_DNN_CTRL_BIAS_EN
          else state_d = BIAS;
`else
          else smp_end = 1'b1;
`endif
        end
      end
      EXEC: begin
        exec_s = 1'b1;
        ra_d   = ra_q + ADDR_W'(1);
        if (ra_q == size_q - ADDR_W'(1)) begin
`ifdef TINY_DNN_CTRL_BIAS_EN
          state_d = BIAS;
`else
          smp_end = 1'b1;
`endif
        end
      end
`ifdef TINY_DNN_CTRL_BIAS_EN
      BIAS: begin
        bias_s  = 1'b1;
        smp_end = 1'b1;
      end
`endif
      DRAIN: begin
        if (!inflight_any && bank_vld_q == 2'b00) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (smp_end) begin
      par_d   = ~par_q;
      rem_d   = rem_q - CNT_W'(1);
      state_d = (rem_q == CNT_W'(1)) ? DRAIN : INIT;
    end
  end

  assign dly_in = '{cmp: smp_end, par: par_q};

  // Completion is applied after acceptance so a same-bank set wins.
  always_comb begin
    accept     = bank_vld_q[rd_ptr_q] && out_ready;
    bank_vld_d = bank_vld_q;
    rd_ptr_d   = rd_ptr_q;
    out_idx_d  = out_idx_q;
    if (run_ld) begin
      rd_ptr_d  = 1'b0;
      out_idx_d = '0;
    end
    if (accept) begin
      bank_vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d             = ~rd_ptr_q;
      out_idx_d            = out_idx_q + CNT_W'(1);
    end
    if (dly_out.cmp) bank_vld_d[dly_out.par] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      size_q     <= '0;
      ra_q       <= '0;
      rem_q      <= '0;
      par_q      <= 1'b0;
      rd_ptr_q   <= 1'b0;
      bank_vld_q <= '0;
      out_idx_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      size_q     <= size_d;
      ra_q       <= ra_d;
      rem_q      <= rem_d;
      par_q      <= par_d;
      rd_ptr_q   <= rd_ptr_d;
      bank_vld_q <= bank_vld_d;
      out_idx_q  <= out_idx_d;
      done_q     <= done_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign init      = init_s;
  assign exec      = exec_s;
  assign bias      = bias_s;
  assign ra        = exec_s ? ra_q : '0;
  assign sum_ip    = dly_out.par;
  assign sum_op    = rd_ptr_q;
  assign out_valid = bank_vld_q[rd_ptr_q];
  assign out_idx   = out_idx_q;
endmodule
